// File: rtl/pio_reg_pkg.sv
// Shared constants for the PIO register bridge: step states, the register map and status word layout.
package pio_reg_pkg;

  typedef enum logic [1:0] {
    STEP_IDLE = 2'd0,
    STEP_RUN  = 2'd1,
    STEP_DONE = 2'd2
  } step_e;

  localparam logic [7:0] CMD_ADDR  = 8'h0F;
  localparam logic [7:0] STAT_BASE = 8'h10;

  localparam int CMD_CLR_TIME   = 0;
  localparam int CMD_CLR_STICKY = 1;

  localparam int SB_LEVEL_LSB = 0;
  localparam int SB_FULL      = 8;
  localparam int SB_EMPTY     = 9;
  localparam int SB_OVF       = 10;
  localparam int SB_UNF       = 11;
  localparam int SB_STEP_LSB  = 12;

endpackage

// File: rtl/evt_fifo.sv
// Synchronous event FIFO with a combinational head; push while full is accepted only alongside a pop.
// Pushes are visible one cycle later; pops from empty and pushes into a full FIFO without a pop are ignored.
module evt_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

endmodule

// File: rtl/pio_reg_bridge.sv
// CPU PIO bridge: byte register file, event FIFO, step timer and timestamp, all driven by PIO level edges.
// Reads return one cycle after the edge; the event source has no backpressure and overflow is flagged sticky.
module pio_reg_bridge
  import pio_reg_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int NREGS      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           addr_in,
  input  logic                 addr_write,
  input  logic [7:0]           wdata,
  input  logic                 swrite,
  input  logic                 sread,
  input  logic                 cread,
  output logic [7:0]           rdata,
  input  logic                 swrite32,
  input  logic [31:0]          wdata32,
  input  logic                 start_step,
  output logic                 stop_step,
  output logic [31:0]          time_out,
  output logic [31:0]          signals_out,
  input  logic                 evt_valid,
  input  logic [7:0]           evt_data,
  output logic [8*NREGS-1:0]   cfg_out
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic aw_q, sw_q, sr_q, cr_q, sw32_q, st_q;
  logic aw_edge, sw_edge, sr_edge, cr_edge, sw32_edge, st_edge;

  logic [7:0]         addr_reg;
  logic [31:0]        step_len;
  logic [31:0]        cnt;
  logic [1:0]         step_state;
  logic [8*NREGS-1:0] cfg;
  logic               ovf, unf;
  logic [7:0]         rd_byte;
  logic               cmd_wr;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]         fifo_head;
  logic [LW-1:0]      fifo_level;

  // Edge registers load 0 in reset so a level held through reset fires on the first free cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      {aw_q, sw_q, sr_q, cr_q, sw32_q, st_q} <= '0;
    end else begin
      {aw_q, sw_q, sr_q, cr_q, sw32_q, st_q} <= {addr_write, swrite, sread, cread, swrite32, start_step};
    end
  end

  assign aw_edge   = addr_write & ~aw_q;
  assign sw_edge   = swrite     & ~sw_q;
  assign sr_edge   = sread      & ~sr_q;
  assign cr_edge   = cread      & ~cr_q;
  assign sw32_edge = swrite32   & ~sw32_q;
  assign st_edge   = start_step & ~st_q;

  assign cmd_wr    = sw_edge && (addr_reg == CMD_ADDR) && (int'(CMD_ADDR) < NREGS);
  assign fifo_pop  = cr_edge && !fifo_empty;
  assign fifo_push = evt_valid && (!fifo_full || fifo_pop);
  assign cfg_out   = cfg;
  assign stop_step = (step_state == STEP_DONE) && start_step;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg <= '0;
      step_len <= '0;
    end else begin
      if (aw_edge)   addr_reg <= addr_in;
      if (sw32_edge) step_len <= wdata32;
    end
  end

  // The command bits are pulses: they drop on any cycle the command register is not being written.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (sw_edge && int'(addr_reg) == i) cfg[8*i +: 8] <= wdata;
        else if (i == int'(CMD_ADDR))       cfg[8*i +: 2] <= 2'b00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                           time_out <= '0;
    else if (cmd_wr && wdata[CMD_CLR_TIME]) time_out <= '0;
    else                                 time_out <= time_out + 32'd1;
  end

  // A new event in the same cycle as the clear command keeps its flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (cmd_wr && wdata[CMD_CLR_STICKY]) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      if (evt_valid && fifo_full && !fifo_pop) ovf <= 1'b1;
      if (cr_edge && fifo_empty)               unf <= 1'b1;
    end
  end

  always_comb begin
    signals_out = '0;
    signals_out[SB_LEVEL_LSB +: 5] = 5'(fifo_level);
    signals_out[SB_FULL]           = fifo_full;
    signals_out[SB_EMPTY]          = fifo_empty;
    signals_out[SB_OVF]            = ovf;
    signals_out[SB_UNF]            = unf;
    signals_out[SB_STEP_LSB +: 2]  = step_state;
  end

  always_comb begin
    rd_byte = 8'h00;
    if (int'(addr_reg) < NREGS) begin
      for (int i = 0; i < NREGS; i++) begin
        if (int'(addr_reg) == i) rd_byte = cfg[8*i +: 8];
      end
    end else if (addr_reg[7:2] == STAT_BASE[7:2]) begin
      rd_byte = signals_out[{addr_reg[1:0], 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        rdata <= 8'h00;
    else if (cr_edge) rdata <= fifo_empty ? 8'h00 : fifo_head;
    else if (sr_edge) rdata <= rd_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_state <= STEP_IDLE;
      cnt        <= '0;
    end else begin
      case (step_state)
        STEP_IDLE: if (st_edge) begin
          step_state <= STEP_RUN;
          cnt        <= step_len;
        end
        STEP_RUN: begin
          if (!start_step)    step_state <= STEP_IDLE;
          else if (cnt == '0) step_state <= STEP_DONE;
          else                cnt        <= cnt - 32'd1;
        end
        STEP_DONE: if (!start_step) step_state <= STEP_IDLE;
        default: step_state <= STEP_IDLE;
      endcase
    end
  end

  evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_evt_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (evt_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
